branch_resolve_ctrl: RTL

//  Controller for the decode-stage branch comparator that drives pc_src from eq_d.

---
 rtl/pipeline_pkg.sv | 16 +
 rtl/branch_hazard_detect.sv | 54 +++++
 rtl/branch_resolve_ctrl.sv | 146 ++++++++++++++
 3 files changed

// File: rtl/pipeline_pkg.sv
// Shared pipeline types and constants.
// Holds the branch FSM state type, forwarding mux encodings and wait width.
package pipeline_pkg;

  typedef enum logic [1:0] {
    IDLE,
    STALL,
    RESOLVE
  } br_state_t;

  localparam logic FWD_RF   = 1'b0;
  localparam logic FWD_ALUM = 1'b1;

  localparam int WAIT_W = 2;

endpackage

// File: rtl/branch_hazard_detect.sv
// Branch operand hazard detector: required stall count and comparator forwarding.
// Ports: rs/rt tags, EX and MEM destination tags/flags in; wait_n, fwd_a, fwd_b out.
module branch_hazard_detect
  import pipeline_pkg::*;
#(
  parameter int REG_ADDR_W = 5
) (
  input  logic [REG_ADDR_W-1:0] rs,
  input  logic [REG_ADDR_W-1:0] rt,
  input  logic [REG_ADDR_W-1:0] write_reg_e,
  input  logic                  reg_write_e,
  input  logic                  mem_to_reg_e,
  input  logic [REG_ADDR_W-1:0] write_reg_m,
  input  logic                  reg_write_m,
  input  logic                  mem_to_reg_m,
  output logic [WAIT_W-1:0]     wait_n,
  output logic                  fwd_a,
  output logic                  fwd_b
);

  logic hit_e;
  logic hit_m;
  logic load_e;
  logic alu_e;
  logic load_m;

  // r0 is hard-wired zero, so a write to it never creates a hazard
  assign hit_e = reg_write_e & (write_reg_e != '0)
               & ((write_reg_e == rs) | (write_reg_e == rt));
  assign hit_m = reg_write_m & (write_reg_m != '0)
               & ((write_reg_m == rs) | (write_reg_m == rt));

  assign load_e = hit_e & mem_to_reg_e;
  assign alu_e  = hit_e & ~mem_to_reg_e;
  assign load_m = hit_m & mem_to_reg_m;

  // priority order yields the maximum of all applicable waits
  always_comb begin
    wait_n = '0;
    unique case (1'b1)
      load_e:         wait_n = WAIT_W'(2);
      alu_e | load_m: wait_n = WAIT_W'(1);
      default:        wait_n = '0;
    endcase
  end

  assign fwd_a = (reg_write_m & ~mem_to_reg_m
                  & (write_reg_m == rs) & (rs != '0))
                 ? FWD_ALUM : FWD_RF;
  assign fwd_b = (reg_write_m & ~mem_to_reg_m
                  & (write_reg_m == rt) & (rt != '0))
                 ? FWD_ALUM : FWD_RF;

endmodule

// File: rtl/branch_resolve_ctrl.sv
// Decode-stage branch controller: hazard stalls, forwarding, resolution, stats.
// Ports: branch/tag inputs in; stall/flush/pc_src/fwd controls and counters out.
module branch_resolve_ctrl
  import pipeline_pkg::*;
#(
  parameter int REG_ADDR_W = 5,
  parameter int CNT_W      = 32
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  beq_d,
  input  logic                  bne_d,
  input  logic [REG_ADDR_W-1:0] rs_d,
  input  logic [REG_ADDR_W-1:0] rt_d,
  input  logic                  eq_d,
  input  logic [REG_ADDR_W-1:0] write_reg_e,
  input  logic                  reg_write_e,
  input  logic                  mem_to_reg_e,
  input  logic [REG_ADDR_W-1:0] write_reg_m,
  input  logic                  reg_write_m,
  input  logic                  mem_to_reg_m,
  output logic                  stall_f,
  output logic                  stall_d,
  output logic                  flush_e,
  output logic                  flush_d,
  output logic                  pc_src_d,
  output logic                  fwd_a_d,
  output logic                  fwd_b_d,
  output logic [CNT_W-1:0]      br_cnt,
  output logic [CNT_W-1:0]      taken_cnt,
  output logic [CNT_W-1:0]      stall_cnt
);

  br_state_t         state;
  br_state_t         state_n;
  logic [WAIT_W-1:0] cnt;
  logic [WAIT_W-1:0] cnt_n;
  logic [WAIT_W-1:0] wait_n;
  logic              fwd_a;
  logic              fwd_b;
  logic              br;
  logic              taken;
  logic              stall;
  logic              resolve;
  logic              pc_src;
  logic [CNT_W-1:0]  br_q;
  logic [CNT_W-1:0]  taken_q;
  logic [CNT_W-1:0]  stall_q;

  branch_hazard_detect #(
    .REG_ADDR_W(REG_ADDR_W)
  ) u_hazard (
    .rs          (rs_d),
    .rt          (rt_d),
    .write_reg_e (write_reg_e),
    .reg_write_e (reg_write_e),
    .mem_to_reg_e(mem_to_reg_e),
    .write_reg_m (write_reg_m),
    .reg_write_m (reg_write_m),
    .mem_to_reg_m(mem_to_reg_m),
    .wait_n      (wait_n),
    .fwd_a       (fwd_a),
    .fwd_b       (fwd_b)
  );

  assign br = beq_d | bne_d;
  // BEQ wins when both opcodes are flagged
  assign taken = beq_d ? eq_d : ~eq_d;

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
    end
  end

  // the IDLE entry cycle is the first stall cycle, so N=1
  // skips STALL and goes straight to RESOLVE
  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    stall   = 1'b0;
    resolve = 1'b0;
    unique case (state)
      IDLE: begin
        if (br) begin
          if (wait_n == '0) begin
            resolve = 1'b1;
          end else begin
            stall   = 1'b1;
            cnt_n   = wait_n;
            state_n = (wait_n == WAIT_W'(1)) ? RESOLVE : STALL;
          end
        end
      end
      STALL: begin
        if (!br) begin
          state_n = IDLE;
          cnt_n   = '0;
        end else begin
          stall = 1'b1;
          cnt_n = cnt - WAIT_W'(1);
          if (cnt_n <= WAIT_W'(1)) state_n = RESOLVE;
        end
      end
      RESOLVE: begin
        state_n = IDLE;
        cnt_n   = '0;
        resolve = br;
      end
      default: begin
        state_n = IDLE;
        cnt_n   = '0;
      end
    endcase
  end

  assign pc_src = resolve & taken;

  always_ff @(posedge clk) begin
    if (reset) begin
      br_q    <= '0;
      taken_q <= '0;
      stall_q <= '0;
    end else begin
      br_q    <= br_q + CNT_W'(resolve);
      taken_q <= taken_q + CNT_W'(pc_src);
      stall_q <= stall_q + CNT_W'(stall);
    end
  end

  assign stall_f   = stall & ~reset;
  assign stall_d   = stall & ~reset;
  assign flush_e   = stall & ~reset;
  assign pc_src_d  = pc_src & ~reset;
  assign flush_d   = pc_src & ~reset;
  assign fwd_a_d   = fwd_a & ~reset;
  assign fwd_b_d   = fwd_b & ~reset;
  assign br_cnt    = reset ? '0 : br_q;
  assign taken_cnt = reset ? '0 : taken_q;
  assign stall_cnt = reset ? '0 : stall_q;

endmodule
